mainbus_mem_ctrl: RTL and testbench

- Secondary-side memory controller on the shared main bus (mainbus_if, secondary modport); the processor is the bus primary.
- Owns one page of word-addressed memory.
- Decodes a multiplexed address/data bus and serves fixed 4-beat read or write bursts to that page.
- Ignores bus traffic addressed to other pages.

---
 rtl/mainbus_pkg.sv | 17 +
 rtl/mc_mem_array.sv | 24 ++
 rtl/mainbus_mem_ctrl.sv | 78 +++++++
 tb/tb_mainbus_mem_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mainbus_pkg.sv
// Shared definitions for the main-bus secondary memory controller:
// default geometry, rw encoding and controller states.
package mainbus_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int OFFSET_W_DEF  = 12;
  localparam int BURST_LEN_DEF = 4;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/mc_mem_array.sv
// One page of word storage: synchronous write port, combinational read port
// so read beats can be driven in the same cycle the beat address is known.
module mc_mem_array #(
  parameter int DATA_W   = 16,
  parameter int OFFSET_W = 12
) (
  input  logic                clk,
  input  logic                we,
  input  logic [OFFSET_W-1:0] addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [2**OFFSET_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mainbus_mem_ctrl.sv
// Secondary-side controller on the multiplexed main bus: decodes its page and
// serves fixed-length read/write bursts into a local word array.
module mainbus_mem_ctrl
  import mainbus_pkg::*;
#(
  parameter int                         DATA_W    = DATA_W_DEF,
  parameter int                         OFFSET_W  = OFFSET_W_DEF,
  parameter logic [DATA_W-OFFSET_W-1:0] PAGE      = 'h2,
  parameter int                         BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              resetH,
  inout  wire [DATA_W-1:0]  AddrData,
  input  logic              AddrValid,
  input  logic              rw
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t              state_reg;
  logic [BEAT_W-1:0]   beat_reg;
  logic [OFFSET_W-1:0] base_reg;
  logic                rw_reg;

  logic [OFFSET_W-1:0] offset;
  logic                mem_we;
  logic                drive;
  logic [DATA_W-1:0]   rdata;
  logic                page_hit;

  assign page_hit = (AddrData[DATA_W-1:OFFSET_W] == PAGE);
  // Offset arithmetic is confined to OFFSET_W bits so bursts wrap inside the page.
  assign offset   = base_reg + OFFSET_W'(beat_reg);
  // Gating with resetH keeps the beat that coincides with a reset edge from landing.
  assign mem_we   = (state_reg == BURST) && (rw_reg == WRITE) && resetH;
  assign drive    = (state_reg == BURST) && (rw_reg == READ);
  assign AddrData = drive ? rdata : 'z;

  always_ff @(posedge clk) begin
    if (!resetH) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (AddrValid && page_hit) begin
            base_reg  <= AddrData[OFFSET_W-1:0];
            rw_reg    <= rw;
            beat_reg  <= '0;
            state_reg <= BURST;
          end
        end
        BURST: begin
          if (beat_reg == LAST_BEAT) begin
            beat_reg  <= '0;
            state_reg <= IDLE;
          end else begin
            beat_reg <= beat_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  mc_mem_array #(
    .DATA_W   (DATA_W),
    .OFFSET_W (OFFSET_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (offset),
    .wdata (AddrData),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mainbus_mem_ctrl.sv
// Directed bench for mainbus_mem_ctrl: bursts, page decode, wrap, back-to-back,
// reset during bursts and AddrValid during a burst.
module tb_mainbus_mem_ctrl;

  localparam logic [15:0] RELEASED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        resetH = 1'b0;
  logic        AddrValid = 1'b0;
  logic        rw = 1'b0;
  logic        tb_en = 1'b0;
  logic [15:0] tb_drv = '0;
  wire  [15:0] bus;

  int checks = 0;
  int errors = 0;

  // A released bus reads all ones through the pullup.
  pullup pu (bus);
  assign bus = tb_en ? tb_drv : 'z;

  always #5 clk = ~clk;

  mainbus_mem_ctrl dut (
    .clk       (clk),
    .resetH    (resetH),
    .AddrData  (bus),
    .AddrValid (AddrValid),
    .rw        (rw)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Address cycle follows the next posedge; beat i data closes at posedge i+1.
  task automatic do_write(input logic [15:0] addr, input logic [0:3][15:0] d,
                          input logic [0:3] av_mask);
    @(posedge clk); #1;
    tb_en = 1'b1; tb_drv = addr; AddrValid = 1'b1; rw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tb_drv    = d[i];
      AddrValid = av_mask[i];
      rw        = av_mask[i];
    end
    @(posedge clk); #1;
    tb_en = 1'b0; AddrValid = 1'b0; rw = 1'b0;
  endtask

  // Returns at the negedge in the middle of the last beat.
  task automatic do_read(input string tag, input logic [15:0] addr,
                         input logic [0:3][15:0] d);
    @(posedge clk); #1;
    tb_en = 1'b1; tb_drv = addr; AddrValid = 1'b1; rw = 1'b1;
    @(posedge clk); #1;
    tb_en = 1'b0; AddrValid = 1'b0; rw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s beat%0d", tag, i), bus, d[i]);
    end
  endtask

  task automatic check_released(input string tag);
    @(negedge clk);
    check_eq(tag, bus, RELEASED);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset bus", bus, RELEASED);
    @(posedge clk); #1;
    resetH = 1'b1;

    // Write then read back
    do_write(16'h2010, {16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3}, 4'b0000);
    do_read("rd 2010", 16'h2010, {16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3});
    check_released("rd 2010 end");

    // Foreign page: ignored on write and never driven on read
    do_write(16'h3010, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4'b0000);
    do_read("rd 3010", 16'h3010, {RELEASED, RELEASED, RELEASED, RELEASED});
    check_released("rd 3010 end");
    do_read("rd 2010 again", 16'h2010, {16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3});

    // Wrap inside the page: 0xFFE,0xFFF,0x000,0x001
    do_write(16'h2000, {16'h000A, 16'h000B, 16'h000C, 16'h000D}, 4'b0000);
    do_write(16'h2FFE, {16'h0001, 16'h0002, 16'h0003, 16'h0004}, 4'b0000);
    do_read("rd 2000 wrap", 16'h2000, {16'h0003, 16'h0004, 16'h000C, 16'h000D});
    do_read("rd 2FFE", 16'h2FFE, {16'h0001, 16'h0002, 16'h0003, 16'h0004});

    // Back-to-back: write address in the cycle right after the last read beat
    do_read("b2b rd 2010", 16'h2010, {16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3});
    fork
      do_write(16'h2020, {16'h5555, 16'h6666, 16'h7777, 16'h8888}, 4'b0000);
      begin
        @(negedge clk);
        check_eq("b2b addr cycle", bus, 16'h2020);
        @(negedge clk);
        check_eq("b2b wr beat0", bus, 16'h5555);
      end
    join
    do_read("rd 2020", 16'h2020, {16'h5555, 16'h6666, 16'h7777, 16'h8888});

    // Reset during write beat 2
    do_write(16'h2040, {16'hEEE0, 16'hEEE1, 16'hEEE2, 16'hEEE3}, 4'b0000);
    @(posedge clk); #1;
    tb_en = 1'b1; tb_drv = 16'h2040; AddrValid = 1'b1; rw = 1'b0;
    @(posedge clk); #1;
    AddrValid = 1'b0; tb_drv = 16'h0101;
    @(posedge clk); #1;
    tb_drv = 16'h0202;
    @(posedge clk); #1;
    tb_drv = 16'h0303; resetH = 1'b0;
    @(posedge clk); #1;
    resetH = 1'b1; tb_drv = 16'h0404;
    @(posedge clk); #1;
    tb_en = 1'b0;
    check_released("post reset idle");
    do_read("rd 2040", 16'h2040, {16'h0101, 16'h0202, 16'hEEE2, 16'hEEE3});

    // Reset during a read releases the driver at that edge
    @(posedge clk); #1;
    tb_en = 1'b1; tb_drv = 16'h2010; AddrValid = 1'b1; rw = 1'b1;
    @(posedge clk); #1;
    tb_en = 1'b0; AddrValid = 1'b0; rw = 1'b0;
    @(negedge clk);
    check_eq("rd reset beat0", bus, 16'hA0A0);
    resetH = 1'b0;
    @(posedge clk); #1;
    resetH = 1'b1;
    @(negedge clk);
    check_eq("rd reset released", bus, RELEASED);

    // AddrValid with a page-hit word during a write burst is ignored
    do_write(16'h2050, {16'h5050, 16'h5151, 16'h5252, 16'h5353}, 4'b0000);
    do_write(16'h2060, {16'h6060, 16'h2050, 16'h6262, 16'h6363}, 4'b0100);
    do_read("rd 2060", 16'h2060, {16'h6060, 16'h2050, 16'h6262, 16'h6363});
    check_released("rd 2060 end");
    do_read("rd 2050", 16'h2050, {16'h5050, 16'h5151, 16'h5252, 16'h5353});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
